// File: rtl/ff_stream_upsizer.sv
// Narrow-to-wide AXI-stream packer: gathers RATIO narrow beats (or fewer on
// up_last) into one registered wide beat with per-lane keep bits.
module ff_stream_upsizer #(
  parameter int unsigned D_WIDTH = 6,
  parameter int unsigned RATIO   = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [D_WIDTH-1:0]         up_data,
  input  logic                       up_valid,
  input  logic                       up_last,
  output logic                       up_ready,
  output logic [D_WIDTH*RATIO-1:0]   down_data,
  output logic [RATIO-1:0]           down_keep,
  output logic                       down_last,
  output logic                       down_valid,
  input  logic                       down_ready
);

  localparam int unsigned CNT_W   = $clog2(RATIO);
  localparam int unsigned W_WIDTH = D_WIDTH * RATIO;

  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [W_WIDTH-1:0] asm_data_q, asm_data_d;
  logic [RATIO-1:0]   asm_keep_q, asm_keep_d;
  logic [W_WIDTH-1:0] data_d;
  logic [RATIO-1:0]   keep_d;
  logic               last_d;
  logic               valid_d;
  logic               push;
  logic               pop;
  logic               complete;

  // Accept a narrow beat whenever the output slot is empty or draining this cycle.
  assign up_ready = ~down_valid | down_ready;
  assign push     = up_valid & up_ready;
  assign pop      = down_valid & down_ready;
  assign complete = (cnt_q == CNT_W'(RATIO - 1)) | up_last;

  // Next-state: fill the assembly lane, or close the group into the output slot.
  always_comb begin
    cnt_d      = cnt_q;
    asm_data_d = asm_data_q;
    asm_keep_d = asm_keep_q;
    data_d     = down_data;
    keep_d     = down_keep;
    last_d     = down_last;
    valid_d    = down_valid;

    if (pop) begin
      valid_d = 1'b0;
    end

    if (push) begin
      if (complete) begin
        // Assembly holds zeros in unfilled lanes, so they load as zero.
        data_d = asm_data_q;
        keep_d = asm_keep_q;
        for (int unsigned i = 0; i < RATIO; i++) begin
          if (CNT_W'(i) == cnt_q) begin
            data_d[i*D_WIDTH +: D_WIDTH] = up_data;
            keep_d[i]                    = 1'b1;
          end
        end
        last_d     = up_last;
        valid_d    = 1'b1;
        cnt_d      = '0;
        asm_data_d = '0;
        asm_keep_d = '0;
      end else begin
        for (int unsigned i = 0; i < RATIO; i++) begin
          if (CNT_W'(i) == cnt_q) begin
            asm_data_d[i*D_WIDTH +: D_WIDTH] = up_data;
            asm_keep_d[i]                    = 1'b1;
          end
        end
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q      <= '0;
      asm_data_q <= '0;
      asm_keep_q <= '0;
      down_data  <= '0;
      down_keep  <= '0;
      down_last  <= 1'b0;
      down_valid <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      asm_data_q <= asm_data_d;
      asm_keep_q <= asm_keep_d;
      down_data  <= data_d;
      down_keep  <= keep_d;
      down_last  <= last_d;
      down_valid <= valid_d;
    end
  end

endmodule

// File: tb/tb_ff_stream_upsizer.sv
// Directed bench for ff_stream_upsizer with a queue-based scoreboard.
module tb_ff_stream_upsizer;

  localparam int unsigned DW = 6;
  localparam int unsigned R  = 4;
  localparam int unsigned WW = DW * R;

  typedef struct packed {
    logic [WW-1:0] data;
    logic [R-1:0]  keep;
    logic          last;
  } beat_t;

  logic          clk;
  logic          rst;
  logic [DW-1:0] up_data;
  logic          up_valid;
  logic          up_last;
  logic          up_ready;
  logic [WW-1:0] down_data;
  logic [R-1:0]  down_keep;
  logic          down_last;
  logic          down_valid;
  logic          down_ready;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_pop = 0;
  int prev_pop = 0;
  beat_t exp_q[$];

  ff_stream_upsizer #(.D_WIDTH(DW), .RATIO(R)) dut (
    .clk(clk), .rst(rst),
    .up_data(up_data), .up_valid(up_valid), .up_last(up_last), .up_ready(up_ready),
    .down_data(down_data), .down_keep(down_keep), .down_last(down_last),
    .down_valid(down_valid), .down_ready(down_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: every popped wide beat must match the head of the scoreboard.
  always @(negedge clk) begin
    beat_t e;
    cyc = cyc + 1;
    if (rst && down_valid && down_ready) begin
      checks = checks + 1;
      if (exp_q.size() == 0) begin
        errors = errors + 1;
        $display("FAIL unexpected_beat got data=%h keep=%h last=%b", down_data, down_keep, down_last);
      end else begin
        e = exp_q.pop_front();
        if (down_data !== e.data || down_keep !== e.keep || down_last !== e.last) begin
          errors = errors + 1;
          $display("FAIL wide_beat got data=%h keep=%h last=%b expected data=%h keep=%h last=%b",
                   down_data, down_keep, down_last, e.data, e.keep, e.last);
        end
      end
      prev_pop = last_pop;
      last_pop = cyc;
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks = checks + 1;
    if (got !== exp) begin
      errors = errors + 1;
      $display("FAIL %s got=%h expected=%h", name, got, exp);
    end
  endtask

  task automatic expect_beat(input logic [WW-1:0] d, input logic [R-1:0] k, input logic l);
    beat_t b;
    b.data = d;
    b.keep = k;
    b.last = l;
    exp_q.push_back(b);
  endtask

  // Drive one narrow beat and return #1 after the edge that accepts it.
  task automatic push(input logic [DW-1:0] d, input logic l, output int stalls);
    int n;
    n = 0;
    stalls = 0;
    up_valid = 1'b1;
    up_data  = d;
    up_last  = l;
    forever begin
      @(negedge clk);
      if (up_ready) break;
      n = n + 1;
      stalls = stalls + 1;
      if (n > 50) begin
        checks = checks + 1;
        errors = errors + 1;
        $display("FAIL push_timeout got up_ready=0 expected up_ready=1");
        break;
      end
    end
    @(posedge clk);
    #1;
    up_valid = 1'b0;
    up_last  = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    int s;
    int total;
    int wait_n;

    rst        = 1'b0;
    up_valid   = 1'b1;
    up_data    = 6'h2A;
    up_last    = 1'b1;
    down_ready = 1'b1;

    // Reset: outputs clear, up_ready high, pushes ignored.
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", 32'(down_valid), 32'd0);
    chk("rst_data", 32'(down_data), 32'd0);
    chk("rst_keep", 32'(down_keep), 32'd0);
    chk("rst_last", 32'(down_last), 32'd0);
    chk("rst_up_ready", 32'(up_ready), 32'd1);
    @(posedge clk);
    #1;
    rst      = 1'b1;
    up_valid = 1'b0;
    up_last  = 1'b0;
    @(negedge clk);
    chk("post_rst_valid", 32'(down_valid), 32'd0);
    idle(1);

    // Full group 1,2,3,4.
    expect_beat(24'h103081, 4'hF, 1'b0);
    push(6'd1, 1'b0, s);
    push(6'd2, 1'b0, s);
    push(6'd3, 1'b0, s);
    chk("full_no_early_valid", 32'(down_valid), 32'd0);
    push(6'd4, 1'b0, s);
    @(negedge clk);
    chk("full_latency_valid", 32'(down_valid), 32'd1);
    @(negedge clk);
    chk("full_one_cycle_valid", 32'(down_valid), 32'd0);
    idle(1);

    // Short packet 5,6(last); following group starts at lane 0.
    expect_beat(24'h000185, 4'h3, 1'b1);
    push(6'd5, 1'b0, s);
    push(6'd6, 1'b1, s);
    idle(2);

    // Back-pressure: group 10..13 stalls while beat 20 waits.
    down_ready = 1'b0;
    expect_beat(24'h34C2CA, 4'hF, 1'b0);
    expect_beat(24'h5D6554, 4'hF, 1'b0);
    push(6'd10, 1'b0, s);
    push(6'd11, 1'b0, s);
    push(6'd12, 1'b0, s);
    push(6'd13, 1'b0, s);
    up_valid = 1'b1;
    up_data  = 6'd20;
    up_last  = 1'b0;
    repeat (5) begin
      @(negedge clk);
      chk("bp_up_ready", 32'(up_ready), 32'd0);
      chk("bp_hold_data", 32'(down_data), 32'h0034C2CA);
      chk("bp_hold_valid", 32'(down_valid), 32'd1);
    end
    @(posedge clk);
    #1;
    down_ready = 1'b1;
    push(6'd20, 1'b0, s);
    push(6'd21, 1'b0, s);
    push(6'd22, 1'b0, s);
    push(6'd23, 1'b0, s);
    idle(2);

    // Streaming 0..11 with no stalls.
    expect_beat(24'h0C2040, 4'hF, 1'b0);
    expect_beat(24'h1C6144, 4'hF, 1'b0);
    expect_beat(24'h2CA248, 4'hF, 1'b0);
    total = 0;
    for (int i = 0; i < 12; i++) begin
      push(6'(i), 1'b0, s);
      total = total + s;
    end
    chk("stream_stalls", 32'(total), 32'd0);
    idle(2);

    // Back-to-back single-beat packets.
    expect_beat(24'h00003F, 4'h1, 1'b1);
    expect_beat(24'h000001, 4'h1, 1'b1);
    push(6'h3F, 1'b1, s);
    push(6'h01, 1'b1, s);
    @(negedge clk);
    #1;
    chk("single_consecutive", 32'(last_pop - prev_pop), 32'd1);
    idle(2);

    // Reset mid-group discards the partial group.
    push(6'd30, 1'b0, s);
    push(6'd31, 1'b0, s);
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_up_ready", 32'(up_ready), 32'd1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    expect_beat(24'h289207, 4'hF, 1'b0);
    push(6'd7, 1'b0, s);
    chk("midrst_valid_1", 32'(down_valid), 32'd0);
    push(6'd8, 1'b0, s);
    chk("midrst_valid_2", 32'(down_valid), 32'd0);
    push(6'd9, 1'b0, s);
    chk("midrst_valid_3", 32'(down_valid), 32'd0);
    push(6'd10, 1'b0, s);
    @(negedge clk);
    chk("midrst_valid_4", 32'(down_valid), 32'd1);

    // Drain: every expected beat must have appeared.
    wait_n = 0;
    while (exp_q.size() != 0 && wait_n < 20) begin
      @(posedge clk);
      wait_n = wait_n + 1;
    end
    idle(2);
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ff_stream_upsizer.md
# ff_stream_upsizer

AXI-stream width up-converter: packs RATIO consecutive narrow beats into one wide beat, with early closure on `up_last` for short packets. It sits upstream of wide consumers, on the side of the flop FIFOs where narrow producer traffic is gathered into wide words. All outputs are registered, and full narrow-side throughput is sustained when the wide side is not back-pressured.

## Interface
- `D_WIDTH`, 6, narrow beat width in bits
- `RATIO`, 4, narrow beats per wide beat; must be ≥ 2; need not be a power of 2
- `clk`  in  1  single clock, all logic on the rising edge
- `rst`  in  1  synchronous, active-low reset
- `up_data`  in  D_WIDTH  narrow beat
- `up_valid`  in  1  narrow beat valid
- `up_last`  in  1  last beat of packet; qualified by `up_valid`
- `up_ready`  out  1  narrow beat accepted when `up_valid & up_ready`
- `down_data`  out  D_WIDTH*RATIO  packed wide beat; lane i = bits [i*D_WIDTH +: D_WIDTH]
- `down_keep`  out  RATIO  lane i holds valid data
- `down_last`  out  1  wide beat closes a packet
- `down_valid`  out  1  wide beat valid
- `down_ready`  in  1  wide beat consumed when `down_valid & down_ready`

## Operation
- **Handshakes.** push = `up_valid & up_ready`; pop = `down_valid & down_ready`.
- **Lane counter.** `cnt` is $clog2(RATIO) bits and counts 0..RATIO-1. It indexes the lane the next pushed beat fills. Lane 0 is the first beat and sits in the LSBs.
- **Push, non-completing.** Applies when `cnt < RATIO-1` and `up_last`=0.
  - `up_data` is written into assembly lane `cnt` and the matching assembly keep bit is set.
  - `cnt` increments by 1.
- **Push, completing.** Applies when `cnt == RATIO-1` or `up_last`=1.
  - The output register loads the assembly lanes with `up_data` inserted in lane `cnt`.
  - Unfilled lanes load zero.
  - `down_keep` loads the assembly keep bits plus bit `cnt`.
  - `down_last` loads `up_last`; `down_valid` loads 1.
  - `cnt`, the assembly keep bits and the assembly data all clear to 0.
- **Pop without completing push.** `down_valid` loads 0. `down_data`, `down_keep` and `down_last` hold their values.
- **Flow control.** `up_ready = ~down_valid | down_ready`.
  - This is the only combinational input-to-output path.
  - No beat is pushed while a wide beat is stalled.
  - `down_data`, `down_keep` and `down_last` are held stable while `down_valid & ~down_ready`.
- **Simultaneous pop and completing push.** The new wide beat is loaded on the same edge and `down_valid` stays 1, so there is no bubble.
- **Packet boundaries.**
  - `up_last` on lane 0 produces `down_keep` = 1 (only bit 0 set).
  - `up_last` on lane RATIO-1 produces a full keep with `down_last`=1.
  - A packet never shares a wide beat with the next packet.
- **Reset.** Applies any cycle `rst`=0 at a clock edge.
  - `down_valid`, `down_last`, `down_data`, `down_keep`, `cnt`, assembly data and assembly keep all go to 0.
  - Any partial group and any undelivered wide beat are discarded.
  - `up_ready` reads 1 after reset.

## Timing
- **Latency.** The completing push at edge N makes `down_valid`=1 in the cycle after edge N. There is no combinational `up_*` → `down_*` data path.
- **Throughput.** One narrow beat per cycle with `down_ready` held 1, and one wide beat per RATIO cycles (or fewer for short packets).
- **Back-to-back short packets.** Single-beat packets with `down_ready`=1 produce one wide beat per cycle.
- **Reset timing.** With `rst` held low, `up_ready`=1 but pushes are ignored. The first push is accepted on the first edge with `rst`=1.
- **`up_last` without `up_valid`.** Has no effect.

## Test plan
- **Full group.** D_WIDTH=6, RATIO=4, `down_ready`=1. Push 1,2,3,4 with `up_last`=0.
  - Required: exactly one wide beat, `down_data`=0x103081, `down_keep`=0xF, `down_last`=0.
  - Required: `down_valid` high for one cycle, one cycle after the 4th push.
- **Short packet.** Push 5, then 6 with `up_last`=1.
  - Required: `down_data`=0x185, `down_keep`=0x3, `down_last`=1.
  - Required: the next group starts at lane 0.
- **Back-pressure.** Complete a group, then hold `down_ready`=0 for 5 cycles while `up_valid`=1.
  - Required: `up_ready`=0 throughout and the wide beat is unchanged.
  - Required: on `down_ready`=1, one pop, then pushes resume with no beat lost or duplicated.
- **Streaming.** Push 12 beats 0..11 continuously with `down_ready`=1.
  - Required: `up_ready` never drops.
  - Required: three wide beats, lanes holding {0,1,2,3}, {4,5,6,7}, {8,9,10,11}.
- **Single-beat packets.** Push single-beat packets 0x3F, 0x01 back-to-back.
  - Required: two consecutive wide beats, each with `down_keep`=0x1 and `down_last`=1.
  - Required: lane 0 = 0x3F, then 0x01; other lanes 0.
- **Reset mid-group.** Push 2 beats, pulse `rst`=0 for 1 cycle, then push 7,8,9,10.
  - Required: `down_valid` stays 0 until the 4th new push.
  - Required: a single wide beat with lanes {7,8,9,10} and `down_keep`=0xF.
